uart_tx0: RTL and testbench

Byte-to-serial UART transmitter, the transmit-side counterpart of the logger's UART receiver. Accepts bytes from the logger core through a write strobe into a small internal FIFO and shifts each byte out as an 8N1 frame. Bit timing comes from the shared 16x oversampling tick produced by `uart_baud`, so TX and RX run at the same baud rate. Sits between the logger's data-formatting logic and the FPGA serial output pin.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud.sv | 41 ++++
 rtl/uart_tx_fifo.sv | 76 +++++++
 rtl/uart_tx0.sv | 164 ++++++++++++++++
 tb/tb_uart_tx0.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver FSM encoding, frame geometry
// and the sizing helper used by the baud, FIFO and transmitter blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int FRAME_BITS     = 10;
    localparam int DATA_BITS      = 8;
    // System clocks per oversampling tick.
    localparam int BAUD_DIV       = 4;

    // Counter width able to hold 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud.sv
// Oversampling tick generator: one-cycle enable every DIV system clocks.
// Shared by the UART receiver and transmitter so both run at the same rate.
module uart_baud
    import uart_pkg::*;
#(
    parameter int DIV = BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic enable
);

    localparam int CW = cnt_width(DIV);

    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;
    logic          en_q;
    logic          en_d;

    always_comb begin
        div_d = div_q + 1'b1;
        en_d  = 1'b0;
        if (div_q == CW'(DIV - 1)) begin
            div_d = '0;
            en_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            en_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            en_q  <= en_d;
        end
    end

    assign enable = en_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO for the UART transmitter. Push is ignored while full,
// pop is ignored while empty; full/empty derive from the registered count.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [cnt_width(DEPTH):0]    count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rd_d;
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    wr_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap for free because DEPTH is a power of two.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/uart_tx0.sv
// 8N1 UART transmitter: bytes enter a small FIFO on a write strobe and are
// shifted out LSB first, one bit per OVERSAMPLE baud ticks, frames back to back.
module uart_tx0
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din_byte,
    input  logic       din_byte_wr,
    output logic       full,
    output logic       overflow,
    output logic       ser_out,
    output logic       busy,
    output logic       tx_done
);

    localparam int SW = cnt_width(OVERSAMPLE);
    localparam int FW = cnt_width(FIFO_DEPTH);

    logic                  tick;
    logic [7:0]            fifo_dout;
    logic [FW:0]           fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;

    uart_state_e           state_q;
    uart_state_e           state_d;
    logic [7:0]            shift_q;
    logic [7:0]            shift_d;
    logic [SW-1:0]         samp_q;
    logic [SW-1:0]         samp_d;
    logic [2:0]            bit_q;
    logic [2:0]            bit_d;
    logic                  ser_q;
    logic                  ser_d;
    logic                  done_q;
    logic                  done_d;
    logic                  ovf_q;
    logic                  samp_last;

    uart_baud u_baud (
        .clk    (clk),
        .rst    (~rst),
        .enable (tick)
    );

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (din_byte_wr),
        .pop   (pop),
        .din   (din_byte),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign samp_last = (samp_q == SW'(OVERSAMPLE - 1));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    ser_d = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        samp_d  = '0;
                        bit_d   = '0;
                        ser_d   = 1'b0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    samp_d = samp_q + 1'b1;
                    if (samp_last) begin
                        samp_d  = '0;
                        bit_d   = '0;
                        ser_d   = shift_q[0];
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    samp_d = samp_q + 1'b1;
                    if (samp_last) begin
                        samp_d = '0;
                        if (bit_q == 3'd7) begin
                            ser_d   = 1'b1;
                            state_d = ST_STOP;
                        end else begin
                            // Present the next bit now so the line changes on this tick.
                            shift_d = shift_q >> 1;
                            ser_d   = shift_q[1];
                            bit_d   = bit_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    samp_d = samp_q + 1'b1;
                    if (samp_last) begin
                        samp_d = '0;
                        done_d = 1'b1;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_dout;
                            bit_d   = '0;
                            ser_d   = 1'b0;
                            state_d = ST_START;
                        end else begin
                            ser_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // The line register resets to idle-high asynchronously so a reset mid-frame
    // releases the line at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            ser_q   <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
            ovf_q   <= din_byte_wr && fifo_full;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign full     = fifo_full;
    assign overflow = ovf_q;
    assign ser_out  = ser_q;
    assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx0.sv
// Bench for uart_tx0: a line-level 8N1 decoder turns ser_out back into bytes,
// which are compared with the bytes the FIFO rules say must be transmitted.
module tb_uart_tx0;
    import uart_pkg::*;

    localparam int BIT_CLKS   = 16 * BAUD_DIV;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din_byte = 8'h00;
    logic       din_byte_wr = 1'b0;
    logic       full, overflow, ser_out, busy, tx_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] rx_q[$];
    int         rx_start_q[$];
    bit         rx_ok_q[$];
    int         done_q[$];
    int         last_start = -1;

    uart_tx0 #(.FIFO_DEPTH(4), .OVERSAMPLE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .din_byte    (din_byte),
        .din_byte_wr (din_byte_wr),
        .full        (full),
        .overflow    (overflow),
        .ser_out     (ser_out),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx_done === 1'b1) done_q.push_back(cyc);

    // Line decoder: a frame is 10 levels each held BIT_CLKS clocks.
    initial begin : line_decoder
        logic       lvl [FRAME_CLKS];
        logic [9:0] bits;
        bit         ab, ok;
        int         st;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && ser_out === 1'b0) begin
                st = cyc;
                last_start = cyc;
                lvl[0] = ser_out;
                ab = 1'b0;
                for (int i = 1; i < FRAME_CLKS; i++) begin
                    @(negedge clk);
                    if (rst !== 1'b1) ab = 1'b1;
                    lvl[i] = ser_out;
                end
                if (!ab) begin
                    ok = 1'b1;
                    for (int b = 0; b < 10; b++) begin
                        bits[b] = lvl[b*BIT_CLKS];
                        for (int j = 0; j < BIT_CLKS; j++)
                            if (lvl[b*BIT_CLKS + j] !== bits[b]) ok = 1'b0;
                    end
                    if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
                    rx_q.push_back(bits[8:1]);
                    rx_start_q.push_back(st);
                    rx_ok_q.push_back(ok);
                end
            end
        end
    end

    task automatic clear_logs();
        rx_q.delete();
        rx_start_q.delete();
        rx_ok_q.delete();
        done_q.delete();
    endtask

    task automatic write_byte(input logic [7:0] b, output int wcyc);
        @(negedge clk);
        din_byte = b;
        din_byte_wr = 1'b1;
        wcyc = cyc + 1;
        @(negedge clk);
        din_byte_wr = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int limit, output bit to);
        int k = 0;
        while (rx_q.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        to = (rx_q.size() < n);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL reset_ser_out got=%b want=1", ser_out); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", full); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done got=%b want=0", tx_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        rst = 1'b1;
        repeat (500 * BAUD_DIV) @(negedge clk);
        checks++; if (last_start != -1) begin errors++; $display("FAIL idle_no_start got_start_cycle=%0d want=none", last_start); end
        checks++; if (ser_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_line got ser_out=%b busy=%b want 1/0", ser_out, busy); end
    endtask

    task automatic test_single();
        int w, lat;
        bit to;
        clear_logs();
        write_byte(8'h55, w);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise got=%b want=1", busy); end
        wait_frames(1, FRAME_CLKS + 16 * BAUD_DIV, to);
        repeat (4) @(negedge clk);
        checks++;
        if (to) begin
            errors++; $display("FAIL single_timeout got frames=%0d want=1", rx_q.size());
        end else begin
            if (rx_q[0] !== 8'h55 || !rx_ok_q[0]) begin errors++; $display("FAIL single_frame got=%h ok=%0d want=55 ok=1", rx_q[0], rx_ok_q[0]); end
            lat = rx_start_q[0] - w;
            checks++; if (lat < 1 || lat > BAUD_DIV) begin errors++; $display("FAIL single_latency got=%0d want=1..%0d", lat, BAUD_DIV); end
            checks++;
            if (done_q.size() != 1) begin
                errors++; $display("FAIL single_done_count got=%0d want=1", done_q.size());
            end else if (done_q[0] - rx_start_q[0] != FRAME_CLKS) begin
                errors++; $display("FAIL single_done_time got=%0d want=%0d", done_q[0] - rx_start_q[0], FRAME_CLKS);
            end
        end
        checks++; if (busy !== 1'b0 || ser_out !== 1'b1) begin errors++; $display("FAIL single_after got busy=%b ser_out=%b want 0/1", busy, ser_out); end
    endtask

    task automatic test_back_to_back();
        bit to;
        clear_logs();
        @(negedge clk); din_byte = 8'hA3; din_byte_wr = 1'b1;
        @(negedge clk); din_byte = 8'h0F;
        @(negedge clk); din_byte_wr = 1'b0;
        wait_frames(2, 2 * FRAME_CLKS + 16 * BAUD_DIV, to);
        repeat (4) @(negedge clk);
        checks++;
        if (to) begin
            errors++; $display("FAIL b2b_timeout got frames=%0d want=2", rx_q.size());
        end else begin
            if (rx_q[0] !== 8'hA3 || !rx_ok_q[0]) begin errors++; $display("FAIL b2b_first got=%h ok=%0d want=a3", rx_q[0], rx_ok_q[0]); end
            checks++; if (rx_q[1] !== 8'h0F || !rx_ok_q[1]) begin errors++; $display("FAIL b2b_second got=%h ok=%0d want=0f", rx_q[1], rx_ok_q[1]); end
            checks++; if (rx_start_q[1] - rx_start_q[0] != FRAME_CLKS) begin errors++; $display("FAIL b2b_gap got=%0d want=%0d", rx_start_q[1] - rx_start_q[0], FRAME_CLKS); end
            checks++;
            if (done_q.size() != 2) begin
                errors++; $display("FAIL b2b_done_count got=%0d want=2", done_q.size());
            end else if (done_q[1] - done_q[0] != FRAME_CLKS) begin
                errors++; $display("FAIL b2b_done_spacing got=%0d want=%0d", done_q[1] - done_q[0], FRAME_CLKS);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b [6];
        logic [7:0] exp_q[$];
        bit to;
        int k = 0;
        clear_logs();
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        // Model: FIFO of 4, first byte leaves on the tick right after its write.
        for (int i = 0; i < 5; i++) exp_q.push_back(b[i]);
        while (dut.tick !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        repeat (BAUD_DIV - 1) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            din_byte = b[i];
            din_byte_wr = 1'b1;
            @(negedge clk);
            if (i == 3) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_early got=%b want=0", full); end
            end
            if (i == 4) begin
                checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full got full=%b ovf=%b want 1/0", full, overflow); end
            end
            if (i == 5) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%b want=1", overflow); end
            end
        end
        din_byte_wr = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got=%b want=0", overflow); end
        wait_frames(5, 5 * FRAME_CLKS + 64 * BAUD_DIV, to);
        repeat (FRAME_CLKS + 16) @(negedge clk);
        checks++;
        if (to || rx_q.size() != 5) begin
            errors++; $display("FAIL ovf_frame_count got=%0d want=5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i] || !rx_ok_q[i]) begin errors++; $display("FAIL ovf_frame%0d got=%h ok=%0d want=%h", i, rx_q[i], rx_ok_q[i], exp_q[i]); end
            end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_reset_midframe();
        int k = 0;
        int st0;
        clear_logs();
        st0 = last_start;
        @(negedge clk); din_byte = 8'hF7; din_byte_wr = 1'b1;
        @(negedge clk); din_byte = 8'h3C;
        @(negedge clk); din_byte = 8'hC3;
        @(negedge clk); din_byte_wr = 1'b0;
        while (last_start == st0 && k < 200) begin @(negedge clk); k++; end
        checks++;
        if (last_start == st0) begin
            errors++; $display("FAIL midrst_no_start got=none want=start");
        end else begin
            while (cyc < last_start + 4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
            // Bit 3 of 0xF7 is 0, so the line is low when reset hits.
            checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL midrst_bit3 got=%b want=0", ser_out); end
            #2 rst = 1'b0;
            #1;
            checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL midrst_ser_async got=%b want=1", ser_out); end
            checks++; if (busy !== 1'b0 || full !== 1'b0 || tx_done !== 1'b0) begin errors++; $display("FAIL midrst_status got busy=%b full=%b done=%b want 0/0/0", busy, full, tx_done); end
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (3 * FRAME_CLKS) @(negedge clk);
            checks++; if (rx_q.size() != 0 || done_q.size() != 0) begin errors++; $display("FAIL midrst_frames got frames=%0d done=%0d want 0/0", rx_q.size(), done_q.size()); end
            checks++; if (busy !== 1'b0 || ser_out !== 1'b1) begin errors++; $display("FAIL midrst_after got busy=%b ser_out=%b want 0/1", busy, ser_out); end
        end
    endtask

    task automatic test_stream();
        logic [7:0] exp_q[$];
        bit to, ovf_seen = 1'b0;
        int sent = 0, k = 0;
        clear_logs();
        while (sent < 16 && k < 20 * FRAME_CLKS) begin
            @(negedge clk);
            k++;
            if (overflow === 1'b1) ovf_seen = 1'b1;
            din_byte_wr = 1'b0;
            if (full === 1'b0) begin
                din_byte = 8'($urandom);
                din_byte_wr = 1'b1;
                exp_q.push_back(din_byte);
                sent++;
            end
        end
        @(negedge clk);
        din_byte_wr = 1'b0;
        wait_frames(16, 17 * FRAME_CLKS, to);
        repeat (8) @(negedge clk);
        checks++; if (ovf_seen || overflow === 1'b1) begin errors++; $display("FAIL stream_overflow got=1 want=0"); end
        checks++;
        if (to || rx_q.size() != 16) begin
            errors++; $display("FAIL stream_count got=%0d want=16", rx_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rx_q[i] !== exp_q[i] || !rx_ok_q[i]) begin errors++; $display("FAIL stream_byte%0d got=%h ok=%0d want=%h", i, rx_q[i], rx_ok_q[i], exp_q[i]); end
                if (i > 0) begin
                    checks++;
                    if (rx_start_q[i] - rx_start_q[i-1] != FRAME_CLKS) begin errors++; $display("FAIL stream_gap%0d got=%0d want=%0d", i, rx_start_q[i] - rx_start_q[i-1], FRAME_CLKS); end
                end
            end
            checks++; if (done_q.size() != 16) begin errors++; $display("FAIL stream_done_count got=%0d want=16", done_q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
